// File: rtl/pressure_pkg.sv
// Shared types and default timing constants for the pressure cycle controller.
package pressure_pkg;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RISE  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_VENT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  localparam logic [15:0] HOLD_TICKS_DEF   = 16'd1000;
  localparam logic [15:0] RISE_TIMEOUT_DEF = 16'd64;
  localparam logic [15:0] VENT_TIMEOUT_DEF = 16'd64;

  function automatic logic is_busy(input state_t s);
    return (s == ST_RISE) || (s == ST_HOLD) || (s == ST_VENT);
  endfunction
endpackage

// File: rtl/tick_timer.sv
// Saturating 16-bit tick counter; advances and clears only on enabled ticks.
module tick_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  output logic [15:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (en) begin
      if (clr) begin
        count <= 16'd0;
      end else if (count != 16'hFFFF) begin
        count <= count + 16'd1;
      end
    end
  end
endmodule

// File: rtl/pressure_ctrl.sv
// Pressurize / hold / vent cycle controller with cover interlock and fault latch.
//   state | meaning
//   IDLE  | waiting for start with cover closed
//   RISE  | pressurizing until high band, bounded by RISE_TIMEOUT
//   HOLD  | bang-bang regulation for HOLD_TICKS
//   VENT  | releasing pressure until zero, bounded by VENT_TIMEOUT
//   DONE  | one-tick completion pulse
//   FAULT | latched until clr_fault with zero pressure
module pressure_ctrl
  import pressure_pkg::*;
#(
  parameter logic [15:0] HOLD_TICKS   = HOLD_TICKS_DEF,
  parameter logic [15:0] RISE_TIMEOUT = RISE_TIMEOUT_DEF,
  parameter logic [15:0] VENT_TIMEOUT = VENT_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               start,
  input  logic               abort,
  input  logic               clr_fault,
  input  logic               S_cover_closed,
  input  logic               S_cover_opened,
  input  logic [15:0]        S_pressure,
  input  logic               S_pressure_low,
  input  logic               S_pressure_medium,
  input  logic               S_pressure_high,
  output logic               X_pressurize,
  output logic               X_cover_lock,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [STATE_W-1:0] state
);
  state_t      state_q, state_d;
  logic [15:0] count;
  logic        clr;
  logic        p_zero;
  logic        xp_d, lock_d;

  assign p_zero = (S_pressure == 16'd0);
  assign clr    = en && (state_d != state_q);
  assign state  = state_q;

  tick_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Within each state the branches follow the tick priority: cover, abort, faults, progress.
  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        ST_IDLE:  if (start && S_cover_closed) state_d = ST_RISE;
        ST_RISE: begin
          if (S_cover_opened)                                    state_d = ST_FAULT;
          else if (abort)                                        state_d = ST_VENT;
          else if (count == RISE_TIMEOUT && !S_pressure_high)    state_d = ST_FAULT;
          else if (S_pressure_high)                              state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (S_cover_opened)            state_d = ST_FAULT;
          else if (abort)                state_d = ST_VENT;
          else if (S_pressure_low)       state_d = ST_FAULT;
          else if (count == HOLD_TICKS)  state_d = ST_VENT;
        end
        ST_VENT: begin
          if (S_cover_opened)                        state_d = ST_FAULT;
          else if (!p_zero && count == VENT_TIMEOUT) state_d = ST_FAULT;
          else if (p_zero)                           state_d = ST_DONE;
        end
        ST_DONE:  state_d = ST_IDLE;
        ST_FAULT: if (clr_fault && p_zero) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the state being entered and registered with it.
  always_comb begin
    xp_d   = 1'b0;
    lock_d = 1'b0;
    case (state_d)
      ST_RISE: begin
        xp_d   = 1'b1;
        lock_d = 1'b1;
      end
      ST_HOLD: begin
        lock_d = 1'b1;
        if (S_pressure_high)        xp_d = 1'b0;
        else if (S_pressure_medium) xp_d = 1'b1;
        else                        xp_d = X_pressurize;
      end
      ST_VENT:  lock_d = 1'b1;
      ST_FAULT: lock_d = !p_zero;
      default: begin
        xp_d   = 1'b0;
        lock_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      X_pressurize <= 1'b0;
      X_cover_lock <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
    end else if (en) begin
      X_pressurize <= xp_d;
      X_cover_lock <= lock_d;
      busy         <= is_busy(state_d);
      done         <= (state_d == ST_DONE);
      fault        <= (state_d == ST_FAULT);
    end
  end
endmodule

// File: tb/tb_pressure_ctrl.sv
// Randomized scenario bench for pressure_ctrl with a per-tick behavioural model and plant.
module tb_pressure_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic        start = 1'b0, abort = 1'b0, clr_fault = 1'b0;
  logic        cov_c = 1'b1, cov_o = 1'b0;
  logic [15:0] pres = 16'd0;
  logic        p_low, p_med, p_high;
  logic        xp, lock, busy, done, fault;
  logic [2:0]  state;

  localparam int IDLE = 0, RISE = 1, HOLD = 2, VENT = 3, DONE = 4, FAULT = 5;

  int n_tests = 0, n_fail = 0;
  int m_st = IDLE, m_cnt = 0, m_xp = 0, m_lock = 0;
  int mode = 0;           // 0 free plant, 1 leaky cover (capped in low band), 2 bench-driven
  int leak = 300, vent_rate = 3000;

  assign p_low  = (pres < 16'd16384);
  assign p_med  = (pres >= 16'd16384) && (pres < 16'd49152);
  assign p_high = (pres >= 16'd49152);

  always #5 clk = ~clk;

  pressure_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .abort(abort),
    .clr_fault(clr_fault), .S_cover_closed(cov_c), .S_cover_opened(cov_o),
    .S_pressure(pres), .S_pressure_low(p_low), .S_pressure_medium(p_med),
    .S_pressure_high(p_high), .X_pressurize(xp), .X_cover_lock(lock),
    .busy(busy), .done(done), .fault(fault), .state(state)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int nx;
    bit hi, mid, lo, pz;
    if (!en) return;
    pz  = (pres == 0);
    hi  = (int'(pres) >= 49152);
    lo  = (int'(pres) < 16384);
    mid = !hi && !lo;
    nx  = m_st;
    case (m_st)
      IDLE:  if (start && cov_c) nx = RISE;
      RISE:  if (cov_o) nx = FAULT; else if (abort) nx = VENT;
             else if (!hi && m_cnt == 64) nx = FAULT; else if (hi) nx = HOLD;
      HOLD:  if (cov_o) nx = FAULT; else if (abort) nx = VENT;
             else if (lo) nx = FAULT; else if (m_cnt == 1000) nx = VENT;
      VENT:  if (cov_o) nx = FAULT; else if (!pz && m_cnt == 64) nx = FAULT;
             else if (pz) nx = DONE;
      DONE:  nx = IDLE;
      FAULT: if (clr_fault && pz) nx = IDLE;
      default: nx = IDLE;
    endcase
    if (nx != m_st) m_cnt = 0;
    else if (m_cnt < 65535) m_cnt++;
    m_st = nx;
    if (nx == RISE) m_xp = 1;
    else if (nx == HOLD) m_xp = hi ? 0 : (mid ? 1 : m_xp);
    else m_xp = 0;
    if (nx == RISE || nx == HOLD || nx == VENT) m_lock = 1;
    else if (nx == FAULT) m_lock = pz ? 0 : 1;
    else m_lock = 0;
  endtask

  task automatic plant_update();
    int p;
    p = int'(pres);
    if (m_xp == 1) p = p + 2517;
    else if (m_st == VENT) p = p - vent_rate;
    else p = p - leak;
    if (p > 65535) p = 65535;
    if (p < 0) p = 0;
    if (mode == 1 && p > 12000) p = 12000;
    pres = p[15:0];
  endtask

  task automatic do_tick();
    model_step();
    @(posedge clk); #1;
    chk("state", int'(state), m_st);
    chk("x_pressurize", int'(xp), m_xp);
    chk("x_cover_lock", int'(lock), m_lock);
    chk("busy", int'(busy), (m_st == RISE || m_st == HOLD || m_st == VENT) ? 1 : 0);
    chk("done", int'(done), (m_st == DONE) ? 1 : 0);
    chk("fault", int'(fault), (m_st == FAULT) ? 1 : 0);
    if (en && mode != 2) plant_update();
  endtask

  task automatic run_until(input int target, input int maxt, input bit rnd);
    int n;
    n = 0;
    while (m_st != target && n < maxt) begin
      en = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
      do_tick();
      n++;
    end
    en = 1'b1;
    chk("reach_state", int'(state), target);
  endtask

  task automatic pulse_start();
    en = 1'b1; start = 1'b1;
    do_tick();
    start = 1'b0;
  endtask

  task automatic wait_cnt(input int c);
    int n;
    n = 0;
    en = 1'b1;
    while (m_cnt != c && n < 2000) begin do_tick(); n++; end
  endtask

  initial begin
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_outs", int'({xp, lock, busy, done, fault}), 0);
    @(negedge clk); rst_n = 1'b1;
    leak = $urandom_range(100, 800); vent_rate = $urandom_range(2000, 5000);

    // cover not closed: start ignored
    cov_c = 1'b0; start = 1'b1; en = 1'b1;
    repeat (4) do_tick();
    start = 1'b0; cov_c = 1'b1;
    chk("start_cover_open", int'(state), IDLE);

    // nominal cycle with random enable gaps
    pulse_start();
    run_until(HOLD, 200, 1'b1);
    run_until(DONE, 3000, 1'b1);
    run_until(IDLE, 20, 1'b1);
    chk("nominal_lock_off", int'(lock), 0);
    chk("nominal_pres_zero", int'(pres), 0);

    // leaky cover: rise timeout
    mode = 1;
    pulse_start();
    run_until(FAULT, 200, 1'b0);
    chk("leak_fault", int'(fault), 1);
    chk("leak_xp", int'(xp), 0);
    mode = 2; pres = 16'd0; clr_fault = 1'b1;
    do_tick();
    clr_fault = 1'b0; mode = 0;
    chk("leak_clr", int'(state), IDLE);

    // cover opened at HOLD tick 100, then clr_fault with/without pressure
    leak = $urandom_range(100, 800);
    pulse_start();
    run_until(HOLD, 200, 1'b0);
    wait_cnt(100);
    cov_o = 1'b1; cov_c = 1'b0;
    do_tick();
    chk("open_hold_fault", int'(state), FAULT);
    mode = 2; pres = 16'd12000; clr_fault = 1'b1;
    repeat (3) do_tick();
    chk("clr_ignored", int'(state), FAULT);
    chk("clr_ignored_lock", int'(lock), 1);
    pres = 16'd0;
    do_tick();
    chk("clr_accepted", int'(state), IDLE);
    clr_fault = 1'b0; cov_o = 1'b0; cov_c = 1'b1; mode = 0;

    // abort with cover opened at RISE tick 5: cover wins
    pulse_start();
    wait_cnt(5);
    abort = 1'b1; cov_o = 1'b1;
    do_tick();
    abort = 1'b0; cov_o = 1'b0;
    chk("abort_open_fault", int'(state), FAULT);
    clr_fault = 1'b1;
    run_until(IDLE, 300, 1'b0);
    clr_fault = 1'b0;

    // abort alone at RISE tick 5
    vent_rate = $urandom_range(2000, 5000);
    pulse_start();
    wait_cnt(5);
    abort = 1'b1;
    do_tick();
    abort = 1'b0;
    chk("abort_vent", int'(state), VENT);
    run_until(DONE, 100, 1'b1);
    run_until(IDLE, 20, 1'b1);

    // enable frozen for 50 cycles in HOLD
    pulse_start();
    run_until(HOLD, 200, 1'b0);
    wait_cnt(300);
    en = 1'b0;
    repeat (50) do_tick();
    chk("freeze_state", int'(state), HOLD);
    run_until(IDLE, 3000, 1'b0);

    // asynchronous reset mid-HOLD
    pulse_start();
    run_until(HOLD, 200, 1'b0);
    repeat (10) do_tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", int'({xp, lock, busy, done, fault}), 0);
    chk("async_rst_state", int'(state), 0);
    m_st = IDLE; m_cnt = 0; m_xp = 0; m_lock = 0;
    mode = 2; pres = 16'd0;
    @(negedge clk); @(negedge clk);
    chk("rst_held_state", int'(state), 0);
    rst_n = 1'b1;
    en = 1'b1;
    do_tick();
    chk("post_rst_idle", int'(state), IDLE);
    mode = 0;
    pulse_start();
    chk("post_rst_start", int'(state), RISE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
